axi_stream_transmitter: RTL and testbench

//  - AXI4-Stream master: registers a free-running 16-bit input word into TDATA beats and frames them into packets.
//  - Generates TLAST, TID, TDEST, TUSER, TKEEP and TSTRB sideband signals.
//  - Exposes a 128-bit history of accepted beats (txstate) for the downstream SHA3 datapath.
//  - Pairs point-to-point with the stream receiver block, which drives TREADY.

---
 rtl/axi_stream_transmitter.sv | 172 +++++++++++++++++
 tb/tb_axi_stream_transmitter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_transmitter.sv
// -----------------------------------------------------------------------------
// axi_stream_transmitter
//
// AXI4-Stream master. Registers a free-running 16-bit input word into TDATA
// beats and frames them into packets of PKT_LEN beats. A packet can be cut
// short with how_to_last. Every beat carries the TID/TDEST/TUSER/TKEEP/TSTRB
// sideband signals. All stream outputs are registered, and TVALID never
// depends on TREADY.
//
// Parameters:
//   PKT_LEN  beats per packet when how_to_last is not used (2..256)
//   DEST_ID  constant value driven on TDEST
//   ID_INIT  TID of the first packet after reset
//
// Ports:
//   ACLK         in   1    clock; all logic on its rising edge
//   ARESETn      in   1    synchronous reset, active-high (1 = reset)
//   TREADY       in   1    sink ready
//   in_data      in   16   payload source, sampled when a beat is loaded
//   how_to_last  in   1    force TLAST on the beat being loaded
//   TKEEP        out  2    byte-keep  (2'b11 while TVALID)
//   TSTRB        out  2    byte-strobe (2'b11 while TVALID)
//   TID          out  8    packet identifier, +1 per packet (wraps)
//   TDEST        out  1    destination (DEST_ID)
//   TUSER        out  1    start-of-packet flag
//   TVALID       out  1    beat valid
//   TLAST        out  1    last beat of packet
//   TDATA        out  16   payload
//   txstate      out  128  history of the last 8 accepted TDATA words
//
// Configuration macro:
//   TXSTATE_EN   when defined, txstate shifts in TDATA on every accepted beat.
//                When undefined, txstate is tied to zero and no history
//                registers are built.
// -----------------------------------------------------------------------------
module axi_stream_transmitter #(
  parameter int         PKT_LEN = 8,
  parameter logic       DEST_ID = 1'b0,
  parameter logic [7:0] ID_INIT = 8'h00
) (
  input  logic         ACLK,
  input  logic         ARESETn,
  input  logic         TREADY,
  input  logic [15:0]  in_data,
  input  logic         how_to_last,
  output logic [1:0]   TKEEP,
  output logic [1:0]   TSTRB,
  output logic [7:0]   TID,
  output logic         TDEST,
  output logic         TUSER,
  output logic         TVALID,
  output logic         TLAST,
  output logic [15:0]  TDATA,
  output logic [127:0] txstate
);

  localparam int CNT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;      // index of the beat currently on the bus
  logic               accept;     // current beat is handed over this edge
  logic               load_beat;  // a new beat enters TDATA this edge
  logic               pkt_start;  // the beat being loaded opens a packet
  logic [CNT_W-1:0]   load_idx;   // index of the beat being loaded
  logic               load_last;  // TLAST for the beat being loaded

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge ACLK) begin
    if (ARESETn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of latches
  // on paths that do not assign state_d.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = LOAD;
      LOAD:    state_d = SEND;
      SEND:    state_d = SEND;  // back-to-back loading happens inside SEND
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    accept    = 1'b0;
    load_beat = 1'b0;
    pkt_start = 1'b0;
    unique case (state_q)
      LOAD: begin
        load_beat = 1'b1;
        pkt_start = 1'b1;
      end
      SEND: begin
        accept    = TVALID && TREADY;
        load_beat = accept;
        pkt_start = accept && TLAST;
      end
      default: ;
    endcase
    // A beat that closes a packet restarts indexing at zero. Otherwise the
    // index advances. It never passes PKT_LEN-1 because that index forces TLAST.
    load_idx  = pkt_start ? '0 : cnt_q + CNT_W'(1);
    load_last = how_to_last || (load_idx == CNT_W'(PKT_LEN - 1));
  end

  // ---------------------------------------------------------------------------
  // Stream registers. They hold their value while stalled, so TDATA, TLAST,
  // TUSER and TID stay stable until the beat is accepted.
  // ---------------------------------------------------------------------------
  always_ff @(posedge ACLK) begin
    if (ARESETn) begin
      TDATA  <= '0;
      TVALID <= 1'b0;
      TLAST  <= 1'b0;
      TUSER  <= 1'b0;
      TKEEP  <= 2'b00;
      TSTRB  <= 2'b00;
      TID    <= ID_INIT;
      cnt_q  <= '0;
    end else begin
      if (load_beat) begin
        TDATA  <= in_data;
        TVALID <= 1'b1;
        TLAST  <= load_last;
        TUSER  <= pkt_start;
        TKEEP  <= 2'b11;
        TSTRB  <= 2'b11;
        cnt_q  <= load_idx;
      end
      if (accept && TLAST) TID <= TID + 8'd1;
    end
  end

  assign TDEST = DEST_ID;

  // ---------------------------------------------------------------------------
  // Accepted-beat history for the SHA3 datapath
  // ---------------------------------------------------------------------------
`ifdef TXSTATE_EN
  logic [127:0] hist_q;

  // NOTE: this history is a shift register, not a RAM. It is reset so that
  // the downstream hash never sees stale words from before the reset.
  always_ff @(posedge ACLK) begin
    if (ARESETn)     hist_q <= '0;
    else if (accept) hist_q <= {hist_q[111:0], TDATA};
  end

  assign txstate = hist_q;
`else
  assign txstate = '0;
`endif

endmodule

// File: tb/tb_axi_stream_transmitter.sv
// -----------------------------------------------------------------------------
// tb_axi_stream_transmitter
//
// Directed bench for axi_stream_transmitter with default parameters
// (PKT_LEN=8, DEST_ID=0, ID_INIT=0). A vector table covers reset, start-up
// and the first packets. Hand-written sequences follow for the stall,
// how_to_last/TID wrap, mid-stall reset and txstate history.
// -----------------------------------------------------------------------------
module tb_axi_stream_transmitter;

  logic         ACLK = 1'b0;
  logic         ARESETn;
  logic         TREADY;
  logic [15:0]  in_data;
  logic         how_to_last;
  logic [1:0]   TKEEP;
  logic [1:0]   TSTRB;
  logic [7:0]   TID;
  logic         TDEST;
  logic         TUSER;
  logic         TVALID;
  logic         TLAST;
  logic [15:0]  TDATA;
  logic [127:0] txstate;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 ACLK = ~ACLK;

  axi_stream_transmitter dut (
    .ACLK        (ACLK),
    .ARESETn     (ARESETn),
    .TREADY      (TREADY),
    .in_data     (in_data),
    .how_to_last (how_to_last),
    .TKEEP       (TKEEP),
    .TSTRB       (TSTRB),
    .TID         (TID),
    .TDEST       (TDEST),
    .TUSER       (TUSER),
    .TVALID      (TVALID),
    .TLAST       (TLAST),
    .TDATA       (TDATA),
    .txstate     (txstate)
  );

  typedef struct {
    logic        rst;
    logic        rdy;
    logic [15:0] din;
    logic        htl;
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        user;
    logic [7:0]  id;
  } vec_t;

  vec_t tbl[20];

  task automatic check(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive inputs, clock once, then sample 1 time unit after the edge.
  task automatic step(input logic rst, input logic rdy, input logic [15:0] d,
                      input logic htl);
    ARESETn     = rst;
    TREADY      = rdy;
    in_data     = d;
    how_to_last = htl;
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_beat(input string name, input logic valid,
                            input logic [15:0] data, input logic last,
                            input logic user, input logic [7:0] id);
    check({name, ".tvalid"}, TVALID, valid);
    check({name, ".tdata"},  TDATA,  data);
    check({name, ".tlast"},  TLAST,  last);
    check({name, ".tuser"},  TUSER,  user);
    check({name, ".tid"},    TID,    id);
    check({name, ".tkeep"},  TKEEP,  valid ? 2'b11 : 2'b00);
    check({name, ".tstrb"},  TSTRB,  valid ? 2'b11 : 2'b00);
    check({name, ".tdest"},  TDEST,  1'b0);
  endtask

  initial begin
    ARESETn     = 1'b1;
    TREADY      = 1'b1;
    in_data     = '0;
    how_to_last = 1'b0;

    // ---- vector table: two reset cycles, IDLE, LOAD, then 17 beats ----
    tbl[0] = '{1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 1'b1, 16'h0101, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b1, 16'h0102, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00};
    for (int k = 3; k < 20; k++) begin
      int idx;
      idx = (k - 3) % 8;
      tbl[k] = '{1'b0, 1'b1, 16'(16'h0100 + k), 1'b0, 1'b1,
                 16'(16'h0100 + k), (idx == 7), (idx == 0), 8'((k - 3) / 8)};
    end

    for (int i = 0; i < 20; i++) begin
      step(tbl[i].rst, tbl[i].rdy, tbl[i].din, tbl[i].htl);
      check_beat($sformatf("vec%0d", i), tbl[i].valid, tbl[i].data,
                 tbl[i].last, tbl[i].user, tbl[i].id);
      check($sformatf("vec%0d.txstate_rst", i), txstate,
            (i < 4) ? 128'h0 : txstate_expect_or_zero(txstate));
    end

    // ---- stall mid-packet with TDATA = 0x0005 ----
    step(1'b0, 1'b1, 16'h0005, 1'b0);
    check_beat("pre_stall", 1'b1, 16'h0005, 1'b0, 1'b0, 8'h02);
    step(1'b0, 1'b0, 16'hAAAA, 1'b0);
    check_beat("stall1", 1'b1, 16'h0005, 1'b0, 1'b0, 8'h02);
    step(1'b0, 1'b0, 16'hBBBB, 1'b1);
    check_beat("stall2", 1'b1, 16'h0005, 1'b0, 1'b0, 8'h02);
    step(1'b0, 1'b0, 16'hCCCC, 1'b0);
    check_beat("stall3", 1'b1, 16'h0005, 1'b0, 1'b0, 8'h02);
    step(1'b0, 1'b1, 16'h0777, 1'b0);
    check_beat("post_stall", 1'b1, 16'h0777, 1'b0, 1'b0, 8'h02);

    // ---- how_to_last held: first forced TLAST closes packet 2 ----
    step(1'b0, 1'b1, 16'hA000, 1'b1);
    check_beat("htl_first", 1'b1, 16'hA000, 1'b1, 1'b0, 8'h02);
    for (int n = 1; n <= 258; n++) begin
      step(1'b0, 1'b1, 16'(16'hA000 + n), 1'b1);
      check_beat($sformatf("htl%0d", n), 1'b1, 16'(16'hA000 + n), 1'b1,
                 1'b1, 8'((2 + n) % 256));
    end

    // ---- stall, then reset while TVALID=1 and TREADY=0 ----
    step(1'b0, 1'b0, 16'h1234, 1'b1);
    check_beat("rst_pre_stall", 1'b1, 16'hA102, 1'b1, 1'b1, 8'h04);
    step(1'b1, 1'b0, 16'h5555, 1'b0);
    check_beat("rst_mid", 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    check("rst_mid.txstate", txstate, 128'h0);

    // ---- restart and accept beats 0x0001..0x0008 ----
    step(1'b0, 1'b1, 16'h0000, 1'b0);
    check_beat("re_idle", 1'b0, 16'h0000, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 16'h0001, 1'b0);
    check_beat("re_load", 1'b1, 16'h0001, 1'b0, 1'b1, 8'h00);
    for (int k = 2; k <= 9; k++) begin
      step(1'b0, 1'b1, 16'(k), 1'b0);
      check_beat($sformatf("hist%0d", k), 1'b1, 16'(k), (k == 8),
                 (k == 9), (k == 9) ? 8'h01 : 8'h00);
    end
`ifdef TXSTATE_EN
    check("txstate_hist", txstate,
          128'h0001_0002_0003_0004_0005_0006_0007_0008);
`else
    check("txstate_tied", txstate, 128'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  // Expected history during the table run. The first accepted beat is
  // 0x0103 at vec4. The history holds the last eight accepted words, up to
  // the current TDATA minus one.
  function automatic logic [127:0] txstate_expect_or_zero(input logic [127:0] unused);
    logic [127:0] h;
    h = '0;
`ifdef TXSTATE_EN
    for (int w = 16'h0103; w < int'(TDATA); w++) h = {h[111:0], 16'(w)};
`endif
    return h | (unused & 128'h0);
  endfunction

endmodule
